// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EXE skid pipeline stage.
//   - default payload field widths and counter width
//   - default NOP instruction (addi x0,x0,0)
//   - stage occupancy state encoding
//   - helper giving the packed payload width
package pipe_pkg;

    localparam int          ADDR_W_DEF   = 15;
    localparam int          XLEN_DEF     = 32;
    localparam int          SIDE_W_DEF   = 1;
    localparam int          CNT_W_DEF    = 16;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    // EMPTY: main invalid; ONE: main valid, skid empty; FULL: both valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Packed payload layout is {pc, inst, imm, rs1, rs2, side}.
    function automatic int payload_w(input int addr_w, input int xlen, input int side_w);
        return addr_w + 4 * xlen + side_w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active-high (count -> 0)
//   inc   : increment this edge (ignored once all-ones)
//   clr   : synchronous clear; wins over inc
//   count : current value
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// ID/EXE pipeline stage register with valid/ready handshake and a 1-entry
// skid buffer. in_ready is a flop (skid empty), so the upstream stall path is
// cut here while still sustaining one entry per cycle.
//   clk, rst            : clock (rising), async active-high reset
//   flush               : synchronous kill of held and incoming entries
//   cnt_clr             : synchronous clear of both performance counters
//   in_valid/in_ready   : upstream handshake; in_* payload from decode
//   out_valid/out_ready : downstream handshake; out_* payload to execute
//   stall_cnt           : saturating count of cycles with out_valid & ~out_ready
//   bubble_cnt          : saturating count of cycles with ~out_valid
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               ADDR_W   = ADDR_W_DEF,
    parameter int               XLEN     = XLEN_DEF,
    parameter int               SIDE_W   = SIDE_W_DEF,
    parameter logic [XLEN-1:0]  NOP_INST = NOP_INST_DEF,
    parameter int               CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [XLEN-1:0]   in_inst,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [XLEN-1:0]   out_inst,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_rs1,
    output logic [XLEN-1:0]   out_rs2,
    output logic [SIDE_W-1:0] out_side,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int PW = payload_w(ADDR_W, XLEN, SIDE_W);

    localparam logic [PW-1:0] NOP_PAY = {{ADDR_W{1'b0}}, NOP_INST,
                                         {(3*XLEN){1'b0}}, {SIDE_W{1'b0}}};

    state_t          state_q, state_d;
    logic [PW-1:0]   main_q, main_d;
    logic [PW-1:0]   skid_q, skid_d;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [PW-1:0]   in_pay;
    logic            acc, ret;

    assign in_pay = {in_pc, in_inst, in_imm, in_rs1, in_rs2, in_side};
    assign acc    = in_valid & in_ready_q;
    assign ret    = out_valid_q & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= NOP_PAY;
            skid_q      <= NOP_PAY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            // Handshake flags are flops decoded from the next state so neither
            // side sees a combinational path through this stage.
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    // Occupancy control. Any slot that is not valid holds NOP, so a
    // valid-blind consumer always observes a NOP on an empty stage.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // An entry accepted in the same cycle is dropped as well.
            state_d = ST_EMPTY;
            main_d  = NOP_PAY;
            skid_d  = NOP_PAY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        main_d  = in_pay;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && ret) begin
                        main_d = in_pay;
                    end else if (acc) begin
                        skid_d  = in_pay;
                        state_d = ST_FULL;
                    end else if (ret) begin
                        main_d  = NOP_PAY;
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the downstream can move.
                    if (ret) begin
                        main_d  = skid_q;
                        skid_d  = NOP_PAY;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = NOP_PAY;
                    skid_d  = NOP_PAY;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign {out_pc, out_inst, out_imm, out_rs1, out_rs2, out_side} = main_q;

    // Counters sample the pre-edge handshake; flush leaves them alone.
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid_q & ~out_ready),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~out_valid_q),
        .clr   (cnt_clr),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int ADDR_W = 15;
    localparam int XLEN   = 32;
    localparam int SIDE_W = 1;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush, cnt_clr;
    logic              in_valid, in_ready;
    logic [ADDR_W-1:0] in_pc;
    logic [XLEN-1:0]   in_inst, in_imm, in_rs1, in_rs2;
    logic [SIDE_W-1:0] in_side;
    logic              out_valid, out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [XLEN-1:0]   out_inst, out_imm, out_rs1, out_rs2;
    logic [SIDE_W-1:0] out_side;
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_skid #(
        .ADDR_W(ADDR_W), .XLEN(XLEN), .SIDE_W(SIDE_W),
        .NOP_INST(32'h0000_0013), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_side(in_side),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_side(out_side),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Payload derived from pc: inst = 0x1000_0000|pc, imm/rs1/rs2 = pc+1/2/3, side = pc[2].
    task automatic drive(input logic v, input logic [ADDR_W-1:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_inst  = 32'h1000_0000 | 32'(pc);
        in_imm   = 32'(pc) + 32'd1;
        in_rs1   = 32'(pc) + 32'd2;
        in_rs2   = 32'(pc) + 32'd3;
        in_side  = pc[2];
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0);
        #2;
        // reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_inst",  out_inst,  32'h13);
        chk("rst_out_pc",    out_pc,    0);
        chk("rst_stall",     stall_cnt, 0);
        chk("rst_bubble",    bubble_cnt, 0);
        #10 rst = 1'b0;
        tick;

        // stream at full throughput
        out_ready = 1'b1;
        drive(1'b1, 15'h10);
        tick;
        chk("str0_valid", out_valid, 1);
        chk("str0_pc",    out_pc,    15'h10);
        chk("str0_inst",  out_inst,  32'h1000_0010);
        chk("str0_ready", in_ready,  1);
        drive(1'b1, 15'h14);
        tick;
        chk("str1_pc",    out_pc,    15'h14);
        chk("str1_rs2",   out_rs2,   32'h17);
        chk("str1_side",  out_side,  1);
        chk("str1_ready", in_ready,  1);
        drive(1'b1, 15'h18);
        tick;
        chk("str2_pc",    out_pc,    15'h18);
        chk("str2_imm",   out_imm,   32'h19);
        chk("str2_ready", in_ready,  1);

        // drain to empty: payload returns to NOP
        drive(1'b0, 15'h1c);
        tick;
        chk("drain_valid", out_valid, 0);
        chk("drain_inst",  out_inst,  32'h13);
        chk("drain_pc",    out_pc,    0);
        chk("drain_rs1",   out_rs1,   0);
        chk("drain_side",  out_side,  0);
        cnt_clr = 1'b1;
        tick;
        chk("clr_bubble", bubble_cnt, 0);
        cnt_clr = 1'b0;
        tick; tick; tick;
        chk("idle_bubble", bubble_cnt, 3);
        chk("idle_stall",  stall_cnt,  0);

        // back-pressure: 3 stalled cycles under a stream
        out_ready = 1'b0;
        drive(1'b1, 15'h20);
        tick;
        chk("bp_a_valid", out_valid, 1);
        chk("bp_a_ready", in_ready,  1);
        chk("bp_a_pc",    out_pc,    15'h20);
        drive(1'b1, 15'h24);
        tick;
        chk("bp_b_ready", in_ready,  0);
        chk("bp_b_pc",    out_pc,    15'h20);
        chk("bp_b_stall", stall_cnt, 1);
        drive(1'b1, 15'h28);
        tick;
        chk("bp_c_ready", in_ready,  0);
        chk("bp_c_inst",  out_inst,  32'h1000_0020);
        tick;
        chk("bp_d_stall", stall_cnt, 3);
        chk("bp_d_pc",    out_pc,    15'h20);
        out_ready = 1'b1;
        tick;
        chk("bp_e_pc",    out_pc,    15'h24);
        chk("bp_e_ready", in_ready,  1);
        chk("bp_e_stall", stall_cnt, 3);
        tick;
        chk("bp_f_pc",    out_pc,    15'h28);
        chk("bp_f_valid", out_valid, 1);
        drive(1'b0, 15'h2c);
        tick;
        chk("bp_g_valid", out_valid, 0);

        // flush while FULL, with upstream still offering
        out_ready = 1'b0;
        drive(1'b1, 15'h30);
        tick;
        drive(1'b1, 15'h34);
        tick;
        chk("fl_full_ready", in_ready, 0);
        drive(1'b1, 15'h38);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_inst",  out_inst,  32'h13);
        chk("fl_ready", in_ready,  1);
        chk("fl_stall_kept", stall_cnt, 5);
        drive(1'b0, 15'h3c);
        out_ready = 1'b1;
        tick;
        chk("fl_after1", out_valid, 0);
        tick;
        chk("fl_after2", out_valid, 0);
        chk("fl_after2_pc", out_pc, 0);

        // entry accepted in the flush cycle is discarded
        drive(1'b1, 15'h3c);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        drive(1'b0, 15'h0);
        chk("fl_acc_valid", out_valid, 0);
        chk("fl_acc_pc",    out_pc,    0);
        tick;
        chk("fl_acc_later", out_valid, 0);

        // async reset between edges while FULL
        out_ready = 1'b0;
        drive(1'b1, 15'h40);
        tick;
        drive(1'b1, 15'h44);
        tick;
        drive(1'b0, 15'h0);
        chk("ar_full_ready", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_ready", in_ready,  1);
        chk("ar_inst",  out_inst,  32'h13);
        chk("ar_pc",    out_pc,    0);
        chk("ar_stall", stall_cnt, 0);
        #1 rst = 1'b0;
        tick;

        // saturation with a 4-bit counter
        out_ready = 1'b0;
        drive(1'b1, 15'h50);
        tick;
        drive(1'b0, 15'h0);
        for (int i = 0; i < 20; i++) tick;
        chk("sat_stall", stall_cnt, 15);
        chk("sat_pc",    out_pc,    15'h50);
        cnt_clr = 1'b1;
        tick;
        cnt_clr = 1'b0;
        chk("sat_clr", stall_cnt, 0);
        tick;
        chk("sat_reinc", stall_cnt, 1);
        out_ready = 1'b1;
        tick;
        chk("sat_drain", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
